mem_stage: RTL and testbench

Memory-access stage of the pipelined 8-bit processor, sitting between the EX/MEM pipeline register and the MEM/WB register. It owns the 256×8 data memory and performs loads and stores with a configurable number of wait states. While an access is in progress it stalls the upstream pipeline. It drives the write-back controls, load data, ALU result and destination register into MEM/WB, inserting a bubble on every stalled cycle.

---
 rtl/mem_stage.sv | 111 +++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with a 256x8 data memory and
// WAIT_STATES extra cycles per load/store; stalls upstream while busy.
//
// Ports:
//   clock, reset   single clock, synchronous active-high reset
//   MemRead        load request from EX/MEM
//   MemWrite       store request from EX/MEM (wins over MemRead)
//   WB             write-back controls from EX/MEM
//   ALUOut         ALU result, also the memory address
//   WriteData      store data
//   RegRD          destination register
//   stall          freezes PC, IF/ID, ID/EX, EX/MEM while an access runs
//   WBout          write-back controls to MEM/WB (bubble while stalled)
//   Memout         load data to MEM/WB (zero unless a load completes)
//   ALUOutout      ALU result to MEM/WB
//   RegRDout       destination register to MEM/WB
module mem_stage #(
   parameter int WAIT_STATES = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       MemRead,
   input  logic       MemWrite,
   input  logic [1:0] WB,
   input  logic [7:0] ALUOut,
   input  logic [7:0] WriteData,
   input  logic       RegRD,
   output logic       stall,
   output logic [1:0] WBout,
   output logic [7:0] Memout,
   output logic [7:0] ALUOutout,
   output logic       RegRDout
);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   localparam logic [2:0] LP_CNT_LOAD =
      (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

   state_t     r_state;
   logic [2:0] r_cnt;
   logic [7:0] r_mem [0:255] = '{default: 8'h00};

   logic w_req;
   logic w_done;
   logic w_pass;
   logic w_stall;
   logic w_load;
   logic w_store;

   assign w_req = MemRead | MemWrite;

   // Completing cycle: zero-wait access straight from IDLE, or the
   // last WAIT cycle. Reset suppresses completion so nothing commits.
   assign w_done = !reset &&
      ((r_state == S_IDLE && w_req && WAIT_STATES == 0) ||
       (r_state == S_WAIT && r_cnt == 3'd0));

   // Non-memory instruction flows through with no added cycles.
   assign w_pass = !reset && r_state == S_IDLE && !w_req;

   assign w_stall = !reset && !w_done && !w_pass;

   // Both requests high is treated as a store.
   assign w_store = w_done && MemWrite;
   assign w_load  = w_done && MemRead && !MemWrite;

   assign stall     = w_stall;
   assign WBout     = (w_done || w_pass) ? WB : 2'b00;
   assign Memout    = w_load ? r_mem[ALUOut] : 8'h00;
   assign ALUOutout = ALUOut;
   assign RegRDout  = RegRD;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_req && WAIT_STATES != 0) begin
                  r_state <= S_WAIT;
                  r_cnt   <= LP_CNT_LOAD;
               end
            end
            S_WAIT: begin
               if (r_cnt == 3'd0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= 3'd0;
            end
         endcase
      end
   end

   // Memory contents survive reset; only a completing store writes.
   always_ff @(posedge clock) begin
      if (w_store) begin
         r_mem[ALUOut] <= WriteData;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage across several
// WAIT_STATES settings (0, 1, 2, 3, 7), one DUT instance per setting.
module tb_mem_stage;

   localparam int N = 5;

   function automatic int ws(input int d);
      case (d)
         0: ws = 0;
         1: ws = 1;
         2: ws = 2;
         3: ws = 3;
         4: ws = 7;
         default: ws = 0;
      endcase
   endfunction

   typedef struct {
      logic [1:0] wb;
      logic [7:0] mem;
      logic [7:0] alu;
      logic       rd;
      int         stalls;
      int         dut;
   } exp_t;

   logic       clock = 1'b0;
   logic       rst  [N];
   logic       mr   [N];
   logic       mw   [N];
   logic [1:0] wb   [N];
   logic [7:0] alu  [N];
   logic [7:0] wd   [N];
   logic       rd   [N];
   logic       st   [N];
   logic [1:0] wbo  [N];
   logic [7:0] mo   [N];
   logic [7:0] ao   [N];
   logic       rdo  [N];

   exp_t sbq[$];
   bit   busy = 1'b0;
   int   act  = 0;
   int   scnt = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < N; g++) begin : g_dut
      mem_stage #(.WAIT_STATES(ws(g))) u_dut (
         .clock     (clock),
         .reset     (rst[g]),
         .MemRead   (mr[g]),
         .MemWrite  (mw[g]),
         .WB        (wb[g]),
         .ALUOut    (alu[g]),
         .WriteData (wd[g]),
         .RegRD     (rd[g]),
         .stall     (st[g]),
         .WBout     (wbo[g]),
         .Memout    (mo[g]),
         .ALUOutout (ao[g]),
         .RegRDout  (rdo[g])
      );
   end

   task automatic chk(input string nm, input int d,
                      input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s dut%0d(ws=%0d) got=%0h exp=%0h",
                  nm, d, ws(d), got, exp);
      end
   endtask

   task automatic idle_in(input int d);
      mr[d] = 1'b0;
      mw[d] = 1'b0;
      wb[d] = 2'b00;
      wd[d] = 8'h00;
      rd[d] = 1'b0;
   endtask

   // Present one instruction; call at posedge+#1. Holds inputs until
   // the DUT drops stall, then returns at the next posedge+#1.
   task automatic access(input int d, input logic r, input logic w,
                         input logic [1:0] b, input logic [7:0] a,
                         input logic [7:0] dat, input logic [7:0] em,
                         input logic rdv);
      exp_t e;
      int n;
      act   = d;
      mr[d] = r;
      mw[d] = w;
      wb[d] = b;
      alu[d] = a;
      wd[d] = dat;
      rd[d] = rdv;
      e.wb = b;
      e.mem = em;
      e.alu = a;
      e.rd = rdv;
      e.stalls = (r | w) ? ws(d) : 0;
      e.dut = d;
      sbq.push_back(e);
      busy = 1'b1;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (st[d] && n < 20);
      if (n >= 20) chk("timeout", d, 1, 0);
      @(posedge clock);
      #1;
      busy = 1'b0;
      idle_in(d);
   endtask

   // Monitor: counts stall cycles and pops on each completion.
   always @(negedge clock) begin
      exp_t e;
      if (busy) begin
         if (st[act]) begin
            scnt++;
         end else begin
            if (sbq.size() == 0) begin
               chk("sb_empty", act, 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("WBout", e.dut, 32'(wbo[e.dut]), 32'(e.wb));
               chk("Memout", e.dut, 32'(mo[e.dut]), 32'(e.mem));
               chk("ALUOutout", e.dut, 32'(ao[e.dut]), 32'(e.alu));
               chk("RegRDout", e.dut, 32'(rdo[e.dut]), 32'(e.rd));
               chk("stall_cycles", e.dut, scnt, e.stalls);
            end
            scnt = 0;
         end
      end
   end

   int dl[4] = '{0, 1, 3, 4};
   int bl[2] = '{0, 4};

   initial begin
      for (int i = 0; i < N; i++) begin
         rst[i] = 1'b1;
         mr[i]  = 1'b1;
         mw[i]  = 1'b0;
         wb[i]  = 2'b11;
         alu[i] = 8'h5A;
         wd[i]  = 8'h00;
         rd[i]  = 1'b1;
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
         chk("rst_stall", i, 32'(st[i]), 0);
         chk("rst_WBout", i, 32'(wbo[i]), 0);
         chk("rst_Memout", i, 32'(mo[i]), 0);
         chk("rst_ALUOutout", i, 32'(ao[i]), 32'h5A);
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
         rst[i] = 1'b0;
         idle_in(i);
         alu[i] = 8'h00;
      end
      @(posedge clock);
      #1;

      // Reset mid-access, WAIT_STATES=3.
      mw[3] = 1'b1;
      alu[3] = 8'h40;
      wd[3] = 8'hAA;
      wb[3] = 2'b01;
      @(posedge clock);
      #1;
      rst[3] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         chk("midrst_stall", 3, 32'(st[3]), 0);
         chk("midrst_WBout", 3, 32'(wbo[3]), 0);
         chk("midrst_Memout", 3, 32'(mo[3]), 0);
         @(posedge clock);
         #1;
      end
      rst[3] = 1'b0;
      idle_in(3);
      access(3, 1'b0, 1'b0, 2'b10, 8'h5A, 8'h00, 8'h00, 1'b0);
      access(3, 1'b1, 1'b0, 2'b11, 8'h40, 8'h00, 8'h00, 1'b1);

      // Store then next-cycle load, WAIT_STATES=1.
      access(1, 1'b0, 1'b1, 2'b00, 8'h10, 8'hC3, 8'h00, 1'b0);
      access(1, 1'b1, 1'b0, 2'b11, 8'h10, 8'h00, 8'hC3, 1'b1);

      // Latency sweep with back-to-back loads.
      foreach (dl[i]) begin
         access(dl[i], 1'b0, 1'b1, 2'b00, 8'h30, 8'(8'h80 + dl[i]),
                8'h00, 1'b0);
         access(dl[i], 1'b1, 1'b0, 2'b11, 8'h30, 8'h00,
                8'(8'h80 + dl[i]), 1'b1);
         access(dl[i], 1'b1, 1'b0, 2'b10, 8'h31, 8'h00, 8'h00, 1'b0);
         access(dl[i], 1'b1, 1'b0, 2'b01, 8'h30, 8'h00,
                8'(8'h80 + dl[i]), 1'b1);
         access(dl[i], 1'b0, 1'b0, 2'b10, 8'h77, 8'h00, 8'h00, 1'b1);
      end

      // Both requests high behaves as a store.
      access(1, 1'b1, 1'b1, 2'b01, 8'h20, 8'h7E, 8'h00, 1'b1);
      access(1, 1'b1, 1'b0, 2'b11, 8'h20, 8'h00, 8'h7E, 1'b0);

      // Address boundaries.
      foreach (bl[i]) begin
         access(bl[i], 1'b0, 1'b1, 2'b00, 8'hFF, 8'hFF, 8'h00, 1'b0);
         access(bl[i], 1'b0, 1'b1, 2'b00, 8'h00, 8'h01, 8'h00, 1'b0);
         access(bl[i], 1'b1, 1'b0, 2'b11, 8'hFF, 8'h00, 8'hFF, 1'b1);
         access(bl[i], 1'b1, 1'b0, 2'b11, 8'h00, 8'h00, 8'h01, 1'b0);
         access(bl[i], 1'b1, 1'b0, 2'b11, 8'hC0, 8'h00, 8'h00, 1'b1);
      end

      // Reset on the completing cycle of a pending store, WAIT_STATES=2.
      access(2, 1'b0, 1'b1, 2'b00, 8'h50, 8'h33, 8'h00, 1'b0);
      mw[2] = 1'b1;
      alu[2] = 8'h50;
      wd[2] = 8'h99;
      wb[2] = 2'b01;
      repeat (2) @(posedge clock);
      #1;
      rst[2] = 1'b1;
      @(negedge clock);
      chk("wrst_stall", 2, 32'(st[2]), 0);
      chk("wrst_WBout", 2, 32'(wbo[2]), 0);
      @(posedge clock);
      #1;
      rst[2] = 1'b0;
      idle_in(2);
      @(negedge clock);
      chk("post_rst_stall", 2, 32'(st[2]), 0);
      @(posedge clock);
      #1;
      access(2, 1'b1, 1'b0, 2'b11, 8'h50, 8'h00, 8'h33, 1'b1);

      repeat (2) @(posedge clock);
      chk("sb_drain", 0, sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
